// File: rtl/jk_latch_driver_pkg.sv
// jk_latch_driver_pkg: command and FSM state encodings shared by the JK latch driver.
package jk_latch_driver_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_PULSE = 2'b10,
    ST_CHECK = 2'b11
  } state_e;

  function automatic logic next_q(cmd_e c, logic q);
    return c == CMD_TOGGLE ? ~q : c == CMD_SET ? 1'b1 : c == CMD_RESET ? 1'b0 : q;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: power-of-two synchronous FIFO; push when full and pop when empty are ignored.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  assign full = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jk_latch_driver.sv
// jk_latch_driver: replays queued set/reset/toggle/hold commands onto a JK latch as
// a j/k setup phase followed by a bounded enable pulse, and tracks the expected q.
module jk_latch_driver
  import jk_latch_driver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD = 2,
  parameter int PULSE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       j,
  output logic       k,
  output logic       enable,
  input  logic       q_in,
  output logic       q_track,
  output logic       mismatch,
  input  logic       mismatch_clr,
  output logic       busy
);

  localparam int CW = $clog2((HOLD > PULSE ? HOLD : PULSE) + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE - 1);

  state_e state_q, state_d;
  cmd_e cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_track_q, q_track_d;
  logic mismatch_q, mismatch_d;
  logic j_q, j_d, k_q, k_d, en_q, en_d;
  logic rdy_q;
  logic push, pop, full, empty;
  logic [1:0] fifo_dout;
  logic [$clog2(DEPTH):0] count;

  jk_cmd_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cmd),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // rdy_q keeps cmd_ready low through reset and for the edge that releases it
  assign cmd_ready = rdy_q && !full;
  assign push = cmd_valid && cmd_ready;
  assign pop = state_q == ST_IDLE && !empty;
  assign busy = state_q != ST_IDLE || count != '0;
  assign j = j_q;
  assign k = k_q;
  assign enable = en_q;
  assign q_track = q_track_q;
  assign mismatch = mismatch_q;

  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    q_track_d = q_track_q;
    mismatch_d = mismatch_q && !mismatch_clr;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          cmd_d = cmd_e'(fifo_dout);
          cnt_d = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_q == HOLD_LAST ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == HOLD_LAST ? ST_PULSE : ST_SETUP;
      end
      ST_PULSE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == PULSE_LAST) begin
          q_track_d = next_q(cmd_q, q_track_q);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (q_in != q_track_q) mismatch_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pin drives follow the current state one edge later, so j/k lead enable by HOLD cycles
    j_d = (state_q == ST_SETUP || state_q == ST_PULSE) && cmd_q[1];
    k_d = (state_q == ST_SETUP || state_q == ST_PULSE) && cmd_q[0];
    en_d = state_q == ST_PULSE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q <= CMD_HOLD;
      cnt_q <= '0;
      q_track_q <= 1'b0;
      mismatch_q <= 1'b0;
      j_q <= 1'b0;
      k_q <= 1'b0;
      en_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      q_track_q <= q_track_d;
      mismatch_q <= mismatch_d;
      j_q <= j_d;
      k_q <= k_d;
      en_q <= en_d;
      rdy_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_latch_driver.sv
// tb_jk_latch_driver: directed checks of the JK latch driver against a behavioural latch.
module tb_jk_latch_driver;
  import jk_latch_driver_pkg::*;

  localparam int DEPTH = 4;
  localparam int HOLD = 2;
  localparam int PULSE = 1;

  logic clk = 1'b0;
  logic rst_n, cmd_valid, cmd_ready, j, k, enable, q_in, q_track, mismatch, mismatch_clr, busy;
  logic [1:0] cmd;
  logic lq, force0;
  int errors = 0;
  int checks = 0;

  jk_latch_driver #(.DEPTH(DEPTH), .HOLD(HOLD), .PULSE(PULSE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_ready    (cmd_ready),
    .j            (j),
    .k            (k),
    .enable       (enable),
    .q_in         (q_in),
    .q_track      (q_track),
    .mismatch     (mismatch),
    .mismatch_clr (mismatch_clr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge enable or negedge rst_n)
    if (!rst_n) lq <= 1'b0;
    else lq <= j && k ? ~lq : j ? 1'b1 : k ? 1'b0 : lq;

  assign q_in = force0 ? 1'b0 : lq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  function automatic logic exp_next(input logic [1:0] c, input logic q);
    case (c)
      2'b01: return 1'b0;
      2'b10: return 1'b1;
      2'b11: return !q;
      default: return q;
    endcase
  endfunction

  int cyc = 0;
  int run = 0;
  logic en_prev = 1'b0, j_prev = 1'b0, k_prev = 1'b0;
  int rises[$];
  logic qts[$];

  always @(negedge clk) begin
    cyc++;
    if (rst_n && enable && !en_prev) begin
      rises.push_back(cyc);
      qts.push_back(q_track);
      chk("jk_stable_into_pulse", {30'd0, j, k}, {30'd0, j_prev, k_prev});
    end
    if (rst_n && !enable && en_prev) chk("pulse_len", run, PULSE);
    run = enable ? run + 1 : 0;
    en_prev = enable;
    j_prev = j;
    k_prev = k;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, g, tmo;
    logic eq;
    logic [1:0] c;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd = 2'b00;
    mismatch_clr = 1'b0;
    force0 = 1'b0;
    repeat (2) tick();
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_enable", enable, 0);
    chk("rst_q_track", q_track, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    chk("ready_at_release", cmd_ready, 0);
    tick();
    chk("ready_after_release", cmd_ready, 1);

    // single set: enable at push+4, busy falls at push+5
    push(CMD_SET);
    chk("set_busy_e0", busy, 1);
    chk("set_en_e0", enable, 0);
    tick();
    chk("set_j_e1", j, 0);
    tick();
    chk("set_j_e2", j, 1);
    chk("set_k_e2", k, 0);
    chk("set_en_e2", enable, 0);
    tick();
    chk("set_en_e3", enable, 0);
    chk("set_j_e3", j, 1);
    tick();
    chk("set_en_e4", enable, 1);
    chk("set_j_e4", j, 1);
    chk("set_k_e4", k, 0);
    chk("set_qt_e4", q_track, 1);
    tick();
    chk("set_en_e5", enable, 0);
    chk("set_j_e5", j, 0);
    chk("set_busy_e5", busy, 0);
    chk("set_qt_e5", q_track, 1);
    chk("set_qin_e5", q_in, 1);
    chk("set_mismatch_e5", mismatch, 0);

    // back-to-back set, reset, toggle, hold
    rises.delete();
    qts.delete();
    cmd_valid = 1'b1;
    cmd = CMD_SET;
    tick();
    cmd = CMD_RESET;
    tick();
    cmd = CMD_TOGGLE;
    tick();
    cmd = CMD_HOLD;
    tick();
    cmd_valid = 1'b0;
    repeat (25) tick();
    chk("b2b_pulses", rises.size(), 4);
    for (int i = 1; i < 4; i++) chk("b2b_period", rises[i] - rises[i-1], 5);
    chk("b2b_qt0", qts[0], 1);
    chk("b2b_qt1", qts[1], 0);
    chk("b2b_qt2", qts[2], 1);
    chk("b2b_qt3", qts[3], 1);
    chk("b2b_mismatch", mismatch, 0);

    // FIFO full: five toggles offered with cmd_valid held high
    rises.delete();
    acc = 0;
    g = 0;
    cmd_valid = 1'b1;
    cmd = CMD_TOGGLE;
    while (acc < 5 && g < 40) begin
      if (cmd_ready) acc++;
      tick();
      g++;
    end
    cmd_valid = 1'b0;
    chk("full_accepted", acc, 5);
    chk("full_ready_low", cmd_ready, 0);
    repeat (30) tick();
    chk("full_executed", rises.size(), DEPTH + 1);
    chk("full_qt", q_track, 0);
    chk("full_qin", q_in, 0);
    chk("full_mismatch", mismatch, 0);

    // mismatch: latch readback forced low during a set
    force0 = 1'b1;
    push(CMD_SET);
    repeat (4) tick();
    chk("mm_before_check", mismatch, 0);
    tick();
    chk("mm_after_check", mismatch, 1);
    force0 = 1'b0;
    push(CMD_RESET);
    repeat (7) tick();
    chk("mm_sticky", mismatch, 1);
    chk("mm_qt_reset", q_track, 0);
    mismatch_clr = 1'b1;
    tick();
    mismatch_clr = 1'b0;
    chk("mm_cleared", mismatch, 0);
    force0 = 1'b1;
    mismatch_clr = 1'b1;
    push(CMD_SET);
    repeat (4) tick();
    chk("mm_clr_held", mismatch, 0);
    tick();
    chk("mm_set_wins", mismatch, 1);
    force0 = 1'b0;
    mismatch_clr = 1'b0;
    tick();
    chk("mm_sticky2", mismatch, 1);
    mismatch_clr = 1'b1;
    tick();
    mismatch_clr = 1'b0;
    chk("mm_cleared2", mismatch, 0);

    // reset in the middle of a toggle pulse with commands still queued
    cmd_valid = 1'b1;
    cmd = CMD_TOGGLE;
    tick();
    cmd = CMD_SET;
    tick();
    cmd = CMD_SET;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_en_high", enable, 1);
    chk("mid_toggle_j", j, 1);
    chk("mid_toggle_k", k, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", enable, 0);
    chk("mid_rst_j", j, 0);
    chk("mid_rst_k", k, 0);
    chk("mid_rst_qt", q_track, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(CMD_SET);
    repeat (5) tick();
    chk("post_rst_qt", q_track, 1);
    chk("post_rst_qin", q_in, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mismatch", mismatch, 0);

    // random run of 200 commands
    rises.delete();
    eq = 1'b1;
    tmo = 0;
    for (int i = 0; i < 200; i++) begin
      c = 2'($urandom_range(0, 3));
      eq = exp_next(c, eq);
      cmd_valid = 1'b1;
      cmd = c;
      g = 0;
      while (!cmd_ready && g < 20) begin
        tick();
        g++;
      end
      if (g == 20) tmo++;
      tick();
    end
    cmd_valid = 1'b0;
    repeat (40) tick();
    chk("rand_timeouts", tmo, 0);
    chk("rand_pulses", rises.size(), 200);
    chk("rand_qt", q_track, eq);
    chk("rand_qin", q_in, eq);
    chk("rand_mismatch", mismatch, 0);
    chk("rand_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
